// File: rtl/pixel_sink_pkg.sv
// Shared types for the pixel sink: engine states, default screen size and the
// layout of one buffered pixel entry.
package pixel_sink_pkg;

  localparam int DEF_WIDTH  = 160;
  localparam int DEF_HEIGHT = 120;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POP   = 2'd1,
    S_WRITE = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [23:0] rgb;
  } pixel_t;

  localparam int ENTRY_W = $bits(pixel_t);

endpackage

// File: rtl/pixel_sink_if.sv
// Pixel bus from the tile drawers plus the framebuffer write port and status,
// as seen by the drawer side (master) and the sink (slave).
interface pixel_sink_if #(
  parameter int ADDR_W      = 15,
  parameter int COLOUR_BITS = 3
);
  logic                       vga_draw_enable_bus;
  logic [7:0]                 vga_x_out_bus;
  logic [7:0]                 vga_y_out_bus;
  logic [23:0]                vga_RGB_out_bus;
  logic                       clear_req;
  logic [23:0]                clear_colour;
  logic                       fb_ready;
  logic                       fb_we;
  logic [ADDR_W-1:0]          fb_addr;
  logic [3*COLOUR_BITS-1:0]   fb_colour;
  logic                       almost_full;
  logic                       overflow;
  logic                       busy;

  modport master (
    output vga_draw_enable_bus, vga_x_out_bus, vga_y_out_bus, vga_RGB_out_bus,
    output clear_req, clear_colour, fb_ready,
    input  fb_we, fb_addr, fb_colour, almost_full, overflow, busy
  );

  modport slave (
    input  vga_draw_enable_bus, vga_x_out_bus, vga_y_out_bus, vga_RGB_out_bus,
    input  clear_req, clear_colour, fb_ready,
    output fb_we, fb_addr, fb_colour, almost_full, overflow, busy
  );
endinterface

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with a registered read port; storage carries no reset
// so it can map onto block RAM.
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 40
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wr_data,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
    if (do_pop)  rd_data <= mem[rd_ptr_reg];
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/pixel_sink.sv
// Receiving end of the VGA pixel bus: buffers pixel strobes, writes them to the
// framebuffer port one by one, and sweeps the whole screen on a clear request.
module pixel_sink
  import pixel_sink_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGHT      = DEF_HEIGHT,
  parameter int ADDR_W      = 15,
  parameter int COLOUR_BITS = 3,
  parameter int DEPTH       = 16
) (
  input  logic          clk,
  input  logic          resetn,
  pixel_sink_if.slave   bus
);
  localparam int CW    = 3 * COLOUR_BITS;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  state_t              state_reg;
  logic                clear_pending_reg;
  logic                fb_we_reg;
  logic [ADDR_W-1:0]   fb_addr_reg;
  logic [CW-1:0]       fb_colour_reg;
  logic                overflow_reg;

  pixel_t              in_pix;
  pixel_t              out_pix;
  logic [ENTRY_W-1:0]  rd_data;
  logic                strobe, in_range, push, pop, full, empty;
  logic [CNT_W-1:0]    count;
  logic [ADDR_W-1:0]   pix_addr;
  logic [CW-1:0]       pix_colour;
  logic [CW-1:0]       clear_reduced;

  assign in_pix   = {bus.vga_x_out_bus, bus.vga_y_out_bus, bus.vga_RGB_out_bus};
  assign out_pix  = rd_data;
  assign strobe   = (bus.vga_draw_enable_bus == 1'b1);
  assign in_range = (32'(bus.vga_x_out_bus) < WIDTH) && (32'(bus.vga_y_out_bus) < HEIGHT);
  assign push     = strobe && in_range && !full;
  assign pop      = (state_reg == S_IDLE) && !clear_pending_reg && !empty;
  assign pix_addr = ADDR_W'(32'(out_pix.y) * WIDTH + 32'(out_pix.x));

  // Keep the top COLOUR_BITS of each 8-bit channel; gi=0 is blue, gi=2 is red.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_reduce
      assign pix_colour[gi*COLOUR_BITS +: COLOUR_BITS]    = out_pix.rgb[gi*8+7 -: COLOUR_BITS];
      assign clear_reduced[gi*COLOUR_BITS +: COLOUR_BITS] = bus.clear_colour[gi*8+7 -: COLOUR_BITS];
    end
  endgenerate

  pixel_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (push),
    .pop     (pop),
    .wr_data (in_pix),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg         <= S_IDLE;
      clear_pending_reg <= 1'b0;
      fb_we_reg         <= 1'b0;
      fb_addr_reg       <= '0;
      fb_colour_reg     <= '0;
      overflow_reg      <= 1'b0;
    end else begin
      if (strobe && in_range && full) overflow_reg <= 1'b1;
      case (state_reg)
        S_IDLE: begin
          if (clear_pending_reg) begin
            state_reg         <= S_CLEAR;
            clear_pending_reg <= 1'b0;
            fb_we_reg         <= 1'b1;
            fb_addr_reg       <= '0;
            fb_colour_reg     <= clear_reduced;
          end else if (!empty) begin
            state_reg <= S_POP;
          end
        end
        S_POP: begin
          state_reg     <= S_WRITE;
          fb_we_reg     <= 1'b1;
          fb_addr_reg   <= pix_addr;
          fb_colour_reg <= pix_colour;
        end
        S_WRITE: begin
          if (bus.fb_ready) begin
            state_reg <= S_IDLE;
            fb_we_reg <= 1'b0;
          end
        end
        S_CLEAR: begin
          // fb_addr doubles as the sweep counter.
          if (bus.fb_ready) begin
            if (fb_addr_reg == LAST_ADDR) begin
              state_reg <= S_IDLE;
              fb_we_reg <= 1'b0;
            end else begin
              fb_addr_reg <= fb_addr_reg + ADDR_W'(1);
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
      if (bus.clear_req && state_reg != S_CLEAR) clear_pending_reg <= 1'b1;
    end
  end

  assign bus.fb_we       = fb_we_reg;
  assign bus.fb_addr     = fb_addr_reg;
  assign bus.fb_colour   = fb_colour_reg;
  assign bus.overflow    = overflow_reg;
  assign bus.almost_full = (count >= CNT_W'(DEPTH - 2));
  assign bus.busy        = (state_reg != S_IDLE) || !empty || clear_pending_reg;
endmodule

// File: tb/tb_pixel_sink.sv
// Self-checking bench for pixel_sink: a transaction-level model of the sink is
// compared against the DUT every cycle, plus directed literal checks.
module tb_pixel_sink;
  localparam int W = 160;
  localparam int H = 120;
  localparam int E_IDLE = 0, E_FETCH = 1, E_WR = 2, E_CLR = 3;

  logic clk;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;
  int   dut_writes = 0;
  int   wlog[$];

  pixel_sink_if #(.ADDR_W(15), .COLOUR_BITS(3)) bus ();

  pixel_sink #(.WIDTH(W), .HEIGHT(H), .ADDR_W(15), .COLOUR_BITS(3), .DEPTH(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int px_addr(input int x, input int y);
    return y * W + x;
  endfunction

  function automatic int px_col(input logic [23:0] rgb);
    int r, g, b;
    r = int'(rgb[23:16]) / 32;
    g = int'(rgb[15:8]) / 32;
    b = int'(rgb[7:0]) / 32;
    return r * 64 + g * 8 + b;
  endfunction

  // Transaction-level model: queue of pending pixels, one write engine.
  int q_addr[$];
  int q_col[$];
  int eng = E_IDLE;
  bit pend = 1'b0;
  bit ovf = 1'b0;
  int cur_addr = 0, cur_col = 0, clr_idx = 0, clr_col = 0;

  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        q_addr.delete(); q_col.delete();
        eng = E_IDLE; pend = 1'b0; ovf = 1'b0;
      end else begin
        int  osz, oeng;
        bit  opend, acc;
        osz   = q_addr.size();
        oeng  = eng;
        opend = pend;
        acc   = (bus.vga_draw_enable_bus === 1'b1) && (int'(bus.vga_x_out_bus) < W)
                && (int'(bus.vga_y_out_bus) < H);
        if (acc && osz == 16) ovf = 1'b1;
        case (oeng)
          E_IDLE: begin
            if (opend) begin
              eng = E_CLR; pend = 1'b0; clr_idx = 0; clr_col = px_col(bus.clear_colour);
            end else if (osz > 0) begin
              cur_addr = q_addr.pop_front();
              cur_col  = q_col.pop_front();
              eng = E_FETCH;
            end
          end
          E_FETCH: eng = E_WR;
          E_WR:    if (bus.fb_ready) eng = E_IDLE;
          default: if (bus.fb_ready) begin
            if (clr_idx == W * H - 1) eng = E_IDLE;
            else clr_idx++;
          end
        endcase
        if (acc && osz < 16) begin
          q_addr.push_back(px_addr(bus.vga_x_out_bus, bus.vga_y_out_bus));
          q_col.push_back(px_col(bus.vga_RGB_out_bus));
        end
        if (bus.clear_req && oeng != E_CLR) pend = 1'b1;
      end
    end
  end

  // Compare process: one packed comparison per cycle, plus write logging.
  initial begin
    forever begin
      logic [27:0] exp_v, act_v;
      bit m_we;
      int m_addr, m_col;
      @(negedge clk);
      m_we   = (eng == E_WR) || (eng == E_CLR);
      m_addr = (eng == E_CLR) ? clr_idx : cur_addr;
      m_col  = (eng == E_CLR) ? clr_col : cur_col;
      exp_v = {m_we, m_we ? 15'(m_addr) : 15'd0, m_we ? 9'(m_col) : 9'd0,
               q_addr.size() >= 14, ovf, (eng != E_IDLE) || (q_addr.size() > 0) || pend};
      act_v = {bus.fb_we, m_we ? bus.fb_addr : 15'd0, m_we ? bus.fb_colour : 9'd0,
               bus.almost_full, bus.overflow, bus.busy};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL cycle_model actual=%h required=%h (t=%0t)", act_v, exp_v, $time);
      end
      if (bus.fb_we && bus.fb_ready) begin
        dut_writes++;
        wlog.push_back((int'(bus.fb_addr) << 9) | int'(bus.fb_colour));
      end
    end
  end

  task automatic strobe(input int x, input int y, input logic [23:0] rgb);
    bus.vga_draw_enable_bus = 1'b1;
    bus.vga_x_out_bus = 8'(x);
    bus.vga_y_out_bus = 8'(y);
    bus.vga_RGB_out_bus = rgb;
    @(posedge clk); #1;
    bus.vga_draw_enable_bus = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (bus.busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(bus.busy), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    int w0, bad, n;
    resetn = 1'b0;
    bus.vga_draw_enable_bus = 1'b0;
    bus.vga_x_out_bus = 8'd0;
    bus.vga_y_out_bus = 8'd0;
    bus.vga_RGB_out_bus = 24'd0;
    bus.clear_req = 1'b0;
    bus.clear_colour = 24'd0;
    bus.fb_ready = 1'b0;

    @(negedge clk);
    chk("reset_we", int'(bus.fb_we), 0);
    chk("reset_addr", int'(bus.fb_addr), 0);
    chk("reset_colour", int'(bus.fb_colour), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_overflow", int'(bus.overflow), 0);
    chk("reset_almost_full", int'(bus.almost_full), 0);
    @(posedge clk); #1 resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: single pixel, 3-cycle latency
    bus.fb_ready = 1'b1;
    strobe(5, 2, 24'hFF8000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t1_we", int'(bus.fb_we), 1);
    chk("t1_addr", int'(bus.fb_addr), 325);
    chk("t1_colour", int'(bus.fb_colour), 'h1E0);
    @(negedge clk);
    chk("t1_we_drop", int'(bus.fb_we), 0);

    // 2: fb_ready held low, outputs hold
    @(posedge clk); #1 bus.fb_ready = 1'b0;
    strobe(10, 20, 24'h123456);
    n = 0;
    while (!bus.fb_we && n < 10) begin @(negedge clk); n++; end
    chk("t2_we_rise", int'(bus.fb_we), 1);
    repeat (10) begin
      @(negedge clk);
      chk("t2_hold", (int'(bus.fb_we) << 24) | (int'(bus.fb_addr) << 9) | int'(bus.fb_colour),
          (1 << 24) | (3210 << 9) | 'h00A);
    end
    w0 = dut_writes;
    @(posedge clk); #1 bus.fb_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("t2_one_write", dut_writes - w0, 1);

    // 3: 20 back-to-back strobes with fb_ready low
    @(posedge clk); #1 bus.fb_ready = 1'b0;
    wlog.delete();
    for (int i = 1; i <= 20; i++) begin
      bus.vga_draw_enable_bus = 1'b1;
      bus.vga_x_out_bus = 8'(i);
      bus.vga_y_out_bus = 8'd3;
      bus.vga_RGB_out_bus = {8'(i), 8'(i), 8'(i)};
      @(posedge clk); #1;
      if (i == 14) chk("t3_af_at13", int'(bus.almost_full), 0);
      if (i == 15) chk("t3_af_at14", int'(bus.almost_full), 1);
    end
    bus.vga_draw_enable_bus = 1'b0;
    chk("t3_overflow", int'(bus.overflow), 1);
    bus.fb_ready = 1'b1;
    wait_idle("t3_drain", 200);
    chk("t3_write_count", wlog.size(), 17);
    bad = 0;
    for (int k = 0; k < wlog.size(); k++)
      if ((wlog[k] >> 9) != 481 + k) bad++;
    chk("t3_order", bad, 0);

    // 4: out-of-range pixels
    pulse_reset();
    bus.fb_ready = 1'b1;
    w0 = dut_writes;
    strobe(160, 0, 24'hFFFFFF);
    strobe(0, 120, 24'hFFFFFF);
    repeat (8) @(negedge clk);
    chk("t4_no_write", dut_writes - w0, 0);
    chk("t4_overflow", int'(bus.overflow), 0);
    chk("t4_busy", int'(bus.busy), 0);

    // 5: full-screen clear with a pixel arriving mid-clear
    @(posedge clk); #1;
    wlog.delete();
    bus.clear_colour = 24'h0000FF;
    bus.clear_req = 1'b1;
    @(posedge clk); #1 bus.clear_req = 1'b0;
    repeat (100) @(posedge clk);
    #1 strobe(1, 1, 24'hFFFFFF);
    wait_idle("t5_finish", 20000);
    chk("t5_write_count", wlog.size(), W * H + 1);
    bad = 0;
    for (int k = 0; k < W * H && k < wlog.size(); k++)
      if (wlog[k] != ((k << 9) | 'h007)) bad++;
    chk("t5_sweep", bad, 0);
    if (wlog.size() > W * H) chk("t5_pixel", wlog[W * H], (161 << 9) | 'h1FF);
    else chk("t5_pixel_missing", wlog.size(), W * H + 1);

    // 6: reset in the middle of a clear
    @(posedge clk); #1 bus.clear_req = 1'b1;
    @(posedge clk); #1 bus.clear_req = 1'b0;
    n = 0;
    while (!(bus.fb_we && bus.fb_addr == 15'd500) && n < 1000) begin @(negedge clk); n++; end
    chk("t6_reach_500", int'(bus.fb_addr), 500);
    #1 resetn = 1'b0;
    #1;
    chk("t6_we_async", int'(bus.fb_we), 0);
    chk("t6_busy_async", int'(bus.busy), 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    w0 = dut_writes;
    repeat (10) @(negedge clk);
    chk("t6_no_write", dut_writes - w0, 0);
    chk("t6_busy", int'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
